ldm_stm_seq: RTL and testbench

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

---
 rtl/ldm_stm_seq.sv | 217 +++++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: walks a 16-bit register list and issues one
// memory beat per register, with optional base-register write-back.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Is_Load,
  input  logic [15:0] Reg_List,
  input  logic [31:0] Base,
  input  logic [3:0]  Rn,
  input  logic        Up,
  input  logic        Pre,
  input  logic        Wb,
  input  logic [31:0] R_Data_A,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_Rdata,
  output logic [3:0]  R_Addr_A,
  output logic        Mem_Req,
  output logic        Mem_Wr,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic        Write_PC,
  output logic [31:0] PC_New,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_is_load;
  logic [15:0] r_list;
  logic [31:0] r_base;
  logic [3:0]  r_rn;
  logic        r_up;
  logic        r_pre;
  logic        r_wb;
  logic [31:0] r_addr;
  logic [31:0] r_final;
  logic        r_skip_wb;

  logic [4:0]  w_cnt;
  logic [31:0] w_n4;
  logic [31:0] w_start;
  logic [31:0] w_final;
  logic [3:0]  w_cur;
  logic [15:0] w_list_nxt;

  function automatic logic [4:0] f_popcount(input logic [15:0] v);
    logic [4:0] sum;
    sum = 5'd0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + {4'd0, v[i]};
    end
    return sum;
  endfunction

  function automatic logic [3:0] f_lowest(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  // Transfers always run at ascending addresses, so decrement modes start low.
  assign w_cnt      = f_popcount(r_list);
  assign w_n4       = {25'd0, w_cnt, 2'b00};
  assign w_start    = r_up ? (r_pre ? (r_base + 32'd4) : r_base)
                           : (r_pre ? (r_base - w_n4) : (r_base - w_n4 + 32'd4));
  assign w_final    = r_up ? (r_base + w_n4) : (r_base - w_n4);
  assign w_cur      = f_lowest(r_list);
  assign w_list_nxt = r_list & ~(16'd1 << w_cur);

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_is_load <= 1'b0;
      r_list    <= 16'd0;
      r_base    <= 32'd0;
      r_rn      <= 4'd0;
      r_up      <= 1'b0;
      r_pre     <= 1'b0;
      r_wb      <= 1'b0;
      r_addr    <= 32'd0;
      r_final   <= 32'd0;
      r_skip_wb <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_is_load <= Is_Load;
            r_list    <= Reg_List;
            r_base    <= Base;
            r_rn      <= Rn;
            r_up      <= Up;
            r_pre     <= Pre;
            r_wb      <= Wb;
          end
        end
        S_SETUP: begin
          r_addr    <= w_start;
          r_final   <= w_final;
          // A loaded base register must not be overwritten by write-back.
          r_skip_wb <= r_is_load & r_list[r_rn];
        end
        S_XFER: begin
          if (Mem_Ready) begin
            r_list <= w_list_nxt;
            r_addr <= r_addr + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    R_Addr_A    = 4'd0;
    Mem_Req     = 1'b0;
    Mem_Wr      = 1'b0;
    Mem_Addr    = 32'd0;
    Mem_Wdata   = 32'd0;
    W_Addr      = 4'd0;
    W_Data      = 32'd0;
    Write_Reg   = 1'b0;
    Write_PC    = 1'b0;
    PC_New      = 32'd0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        Busy = 1'b1;
        if (r_list == 16'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        Busy      = 1'b1;
        Mem_Req   = 1'b1;
        Mem_Addr  = r_addr;
        R_Addr_A  = w_cur;
        Mem_Wr    = ~r_is_load;
        Mem_Wdata = R_Data_A;
        if (Mem_Ready) begin
          if (r_is_load && (w_cur == 4'd15)) begin
            Write_PC = 1'b1;
            PC_New   = Mem_Rdata;
          end else if (r_is_load) begin
            Write_Reg = 1'b1;
            W_Addr    = w_cur;
            W_Data    = Mem_Rdata;
          end else begin
            Write_Reg = 1'b0;
          end
          if (w_list_nxt != 16'd0) begin
            w_state_nxt = S_XFER;
          end else if (r_wb && !r_skip_wb) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_WB: begin
        Busy        = 1'b1;
        Write_Reg   = 1'b1;
        W_Addr      = r_rn;
        W_Data      = r_final;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: hand-computed beats, writes and timing.
module tb_ldm_stm_seq;

  logic        clk;
  logic        Rst;
  logic        Start;
  logic        Is_Load;
  logic [15:0] Reg_List;
  logic [31:0] Base;
  logic [3:0]  Rn;
  logic        Up;
  logic        Pre;
  logic        Wb;
  logic [31:0] R_Data_A;
  logic        Mem_Ready;
  logic [31:0] Mem_Rdata;
  logic [3:0]  R_Addr_A;
  logic        Mem_Req;
  logic        Mem_Wr;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_Wdata;
  logic [3:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic        Write_PC;
  logic [31:0] PC_New;
  logic        Busy;
  logic        Done;

  int total_cnt;
  int bad_cnt;

  ldm_stm_seq dut (
    .clk(clk), .Rst(Rst), .Start(Start), .Is_Load(Is_Load), .Reg_List(Reg_List),
    .Base(Base), .Rn(Rn), .Up(Up), .Pre(Pre), .Wb(Wb), .R_Data_A(R_Data_A),
    .Mem_Ready(Mem_Ready), .Mem_Rdata(Mem_Rdata), .R_Addr_A(R_Addr_A),
    .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg), .Write_PC(Write_PC),
    .PC_New(PC_New), .Busy(Busy), .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs checked after a further #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".req"}, {31'd0, Mem_Req}, 32'd0);
    chk({tag, ".wreg"}, {31'd0, Write_Reg}, 32'd0);
    chk({tag, ".wpc"}, {31'd0, Write_PC}, 32'd0);
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] addr, input logic [3:0] ra,
                          input logic wr);
    chk({tag, ".req"}, {31'd0, Mem_Req}, 32'd1);
    chk({tag, ".addr"}, Mem_Addr, addr);
    chk({tag, ".raddr"}, {28'd0, R_Addr_A}, {28'd0, ra});
    chk({tag, ".wr"}, {31'd0, Mem_Wr}, {31'd0, wr});
  endtask

  task automatic chk_wreg(input string tag, input logic en, input logic [3:0] wa,
                          input logic [31:0] wd);
    chk({tag, ".wreg"}, {31'd0, Write_Reg}, {31'd0, en});
    if (en) begin
      chk({tag, ".waddr"}, {28'd0, W_Addr}, {28'd0, wa});
      chk({tag, ".wdata"}, W_Data, wd);
    end else begin
      chk({tag, ".wpc"}, {31'd0, Write_PC}, 32'd0);
    end
  endtask

  task automatic go(input logic ld, input logic [15:0] lst, input logic [31:0] bs,
                    input logic [3:0] rn_v, input logic up_v, input logic pre_v,
                    input logic wb_v);
    Start = 1'b1; Is_Load = ld; Reg_List = lst; Base = bs;
    Rn = rn_v; Up = up_v; Pre = pre_v; Wb = wb_v;
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    Rst = 1'b0; Start = 1'b0; Is_Load = 1'b0; Reg_List = 16'd0; Base = 32'd0;
    Rn = 4'd0; Up = 1'b0; Pre = 1'b0; Wb = 1'b0; R_Data_A = 32'd0;
    Mem_Ready = 1'b1; Mem_Rdata = 32'd0;
    repeat (3) step();
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    chk_quiet("rst");
    Rst = 1'b1;
    step();

    // STM IA, write-back: beats R1@0x100, R2@0x104, WB R13=0x108, Done in cycle 5.
    go(1'b0, 16'h0006, 32'h0000_0100, 4'd13, 1'b1, 1'b0, 1'b1);
    #1 chk("ia.idle_busy", {31'd0, Busy}, 32'd0);
    step(); Start = 1'b0; #1;
    chk("ia.setup_busy", {31'd0, Busy}, 32'd1);
    chk_quiet("ia.setup");
    step(); R_Data_A = 32'hAAAA_0001; #1;
    chk_beat("ia.b1", 32'h0000_0100, 4'd1, 1'b1);
    chk("ia.b1.wdata", Mem_Wdata, 32'hAAAA_0001);
    chk_wreg("ia.b1", 1'b0, 4'd0, 32'd0);
    step(); R_Data_A = 32'hAAAA_0002; #1;
    chk_beat("ia.b2", 32'h0000_0104, 4'd2, 1'b1);
    chk("ia.b2.wdata", Mem_Wdata, 32'hAAAA_0002);
    step(); #1;
    chk("ia.wb.req", {31'd0, Mem_Req}, 32'd0);
    chk_wreg("ia.wb", 1'b1, 4'd13, 32'h0000_0108);
    step(); #1;
    chk("ia.done", {31'd0, Done}, 32'd1);
    step(); #1;
    chk("ia.after.done", {31'd0, Done}, 32'd0);
    chk("ia.after.busy", {31'd0, Busy}, 32'd0);

    // LDM DB with R15: R0<=M[0x1F8], PC<=M[0x1FC], WB R2=0x1F8.
    go(1'b1, 16'h8001, 32'h0000_0200, 4'd2, 1'b0, 1'b1, 1'b1);
    step(); Start = 1'b0;
    step(); Mem_Rdata = 32'h1111_1111; #1;
    chk_beat("db.b1", 32'h0000_01F8, 4'd0, 1'b0);
    chk_wreg("db.b1", 1'b1, 4'd0, 32'h1111_1111);
    chk("db.b1.wpc", {31'd0, Write_PC}, 32'd0);
    step(); Mem_Rdata = 32'h2222_2222; #1;
    chk_beat("db.b2", 32'h0000_01FC, 4'd15, 1'b0);
    chk("db.b2.wpc", {31'd0, Write_PC}, 32'd1);
    chk("db.b2.pc", PC_New, 32'h2222_2222);
    chk("db.b2.wreg", {31'd0, Write_Reg}, 32'd0);
    step(); #1;
    chk_wreg("db.wb", 1'b1, 4'd2, 32'h0000_01F8);
    step(); #1;
    chk("db.done", {31'd0, Done}, 32'd1);
    step();

    // LDM IB with a 3-cycle stall on beat 1, no write-back.
    go(1'b1, 16'h0003, 32'h0000_0300, 4'd5, 1'b1, 1'b1, 1'b0);
    step(); Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); Mem_Ready = 1'b0; Mem_Rdata = 32'hDEAD_0000; #1;
      chk_beat("stall", 32'h0000_0304, 4'd0, 1'b0);
      chk("stall.wreg", {31'd0, Write_Reg}, 32'd0);
      chk("stall.wpc", {31'd0, Write_PC}, 32'd0);
    end
    step(); Mem_Ready = 1'b1; Mem_Rdata = 32'h0000_0033; #1;
    chk_beat("stall.b1", 32'h0000_0304, 4'd0, 1'b0);
    chk_wreg("stall.b1", 1'b1, 4'd0, 32'h0000_0033);
    step(); Mem_Rdata = 32'h0000_0034; #1;
    chk_beat("stall.b2", 32'h0000_0308, 4'd1, 1'b0);
    chk_wreg("stall.b2", 1'b1, 4'd1, 32'h0000_0034);
    step(); #1;
    chk("stall.done", {31'd0, Done}, 32'd1);
    chk("stall.done.wreg", {31'd0, Write_Reg}, 32'd0);
    step();

    // Empty list: no beats, no writes (even with Wb=1), Done 2 cycles after Start.
    go(1'b1, 16'h0000, 32'h0000_0700, 4'd1, 1'b1, 1'b0, 1'b1);
    step(); Start = 1'b0; #1;
    chk_quiet("empty.setup");
    chk("empty.setup.done", {31'd0, Done}, 32'd0);
    step(); #1;
    chk("empty.done", {31'd0, Done}, 32'd1);
    chk_quiet("empty.done");
    step(); #1;
    chk("empty.idle", {31'd0, Busy}, 32'd0);

    // LDM DA with Rn=3 in the list: loaded R3 wins, write-back skipped.
    go(1'b1, 16'h0018, 32'h0000_0400, 4'd3, 1'b0, 1'b0, 1'b1);
    step(); Start = 1'b0;
    step(); Mem_Rdata = 32'h0000_0044; #1;
    chk_beat("rnin.b1", 32'h0000_03FC, 4'd3, 1'b0);
    chk_wreg("rnin.b1", 1'b1, 4'd3, 32'h0000_0044);
    step(); Mem_Rdata = 32'h0000_0055; #1;
    chk_beat("rnin.b2", 32'h0000_0400, 4'd4, 1'b0);
    chk_wreg("rnin.b2", 1'b1, 4'd4, 32'h0000_0055);
    step(); #1;
    chk("rnin.done", {31'd0, Done}, 32'd1);
    chk_wreg("rnin.nowb", 1'b0, 4'd0, 32'd0);
    step();

    // Reset in the middle of a stalled STM beat.
    go(1'b0, 16'h0003, 32'h0000_0500, 4'd0, 1'b1, 1'b0, 1'b0);
    step(); Start = 1'b0;
    step(); Mem_Ready = 1'b0; R_Data_A = 32'h5555_5555; #1;
    chk_beat("mid.pre", 32'h0000_0500, 4'd0, 1'b1);
    Rst = 1'b0; #1;
    chk("mid.req", {31'd0, Mem_Req}, 32'd0);
    chk("mid.addr", Mem_Addr, 32'd0);
    chk("mid.wr", {31'd0, Mem_Wr}, 32'd0);
    chk("mid.wdata", Mem_Wdata, 32'd0);
    chk("mid.busy", {31'd0, Busy}, 32'd0);
    step(); Mem_Ready = 1'b1; #1;
    chk_quiet("mid.held");
    Rst = 1'b1;

    // First Start after reset accepted; Start while busy ignored.
    go(1'b1, 16'h0001, 32'h0000_0600, 4'd7, 1'b1, 1'b0, 1'b0);
    step(); go(1'b1, 16'hFFFF, 32'h0000_0900, 4'd9, 1'b0, 1'b1, 1'b1); #1;
    chk("post.setup.busy", {31'd0, Busy}, 32'd1);
    step(); Mem_Rdata = 32'h0000_0066; #1;
    chk_beat("post.b1", 32'h0000_0600, 4'd0, 1'b0);
    chk_wreg("post.b1", 1'b1, 4'd0, 32'h0000_0066);
    step(); #1;
    chk("post.done", {31'd0, Done}, 32'd1);
    chk("post.done.req", {31'd0, Mem_Req}, 32'd0);
    step(); Start = 1'b0; #1;
    chk("post.idle", {31'd0, Busy}, 32'd0);
    step(); #1;
    chk("post.idle2", {31'd0, Busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
